// File: rtl/uart_rx_fifo.sv
// Buffered 8N1 UART receiver: 2-flop line synchroniser, start-glitch rejection,
// framing-error detection and a first-word-fall-through byte FIFO.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Line synchroniser (idles high so reset does not look like a start bit)
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_e        state, state_d;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             push;
  logic             frame_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      clk_cnt <= clk_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    push      = 1'b0;
    frame_evt = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      // Re-check the line half a bit in; a high line means the edge was a glitch.
      START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_d        = '0;
          shift_d[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_evt = 1'b1;
            state_d   = BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end

      // Held-low line after a bad stop bit must not retrigger a start.
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;
  logic             ovr_evt;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign do_push = push && (!full || do_pop);
  assign ovr_evt = push && !do_push;
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: storage is not reset; entries are only visible through count, which
  // is reset, so clearing the array would add nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; a new event wins over a simultaneous clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_evt)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;

      if (ovr_evt)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: clean frames, FIFO full/overrun, glitch,
// framing error, simultaneous push/pop at full and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  logic [14:0] obs;
  logic [14:0] exp_v;

  assign obs = {rd_data, empty, full, count, frame_err, overrun};

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Expected status word: {rd_data, empty, full, count, frame_err, overrun}
  function automatic logic [14:0] st(input logic [7:0] d, input logic e, input logic f,
                                     input logic [2:0] c, input logic fe, input logic ov);
    return {d, e, f, c, fe, ov};
  endfunction

  // Advance n rising edges, then step 1 ns off the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_hold);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    if (!stop_bit) begin
      tick(low_hold);
      rx = 1'b1;
      tick(10);
    end
    rx = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    exp_v = st(8'h00, 1, 0, 3'd0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset: got %h want %h", obs, exp_v); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    fork
      send_frame(8'h14, 1'b1, 0);
      begin
        tick(987);
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL single_early: count=%0d want 0", count); end
        tick(7);
        exp_v = st(8'h14, 0, 0, 3'd1, 0, 0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL single_990: got %h want %h", obs, exp_v); end
      end
    join
    pop();
    exp_v = st(8'h00, 1, 0, 3'd0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL single_pop: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] frames [4];
    frames = '{8'h14, 8'h2C, 8'h42, 8'h14};
    for (int i = 0; i < 4; i++) send_frame(frames[i], 1'b1, 0);
    exp_v = st(8'h14, 0, 1, 3'd4, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL b2b_full: got %h want %h", obs, exp_v); end
    send_frame(8'h55, 1'b1, 0);
    exp_v = st(8'h14, 0, 1, 3'd4, 0, 1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL b2b_overrun: got %h want %h", obs, exp_v); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data !== frames[i]) begin
        bad++; $display("FAIL b2b_read%0d: got %h want %h", i, rd_data, frames[i]);
      end
      pop();
    end
    exp_v = st(8'h00, 1, 0, 3'd0, 0, 1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL b2b_drained: got %h want %h", obs, exp_v); end
    pulse_clr();
    exp_v = st(8'h00, 1, 0, 3'd0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL b2b_clr: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    tick(30);
    rx = 1'b1;
    tick(120);
    exp_v = st(8'h00, 1, 0, 3'd0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL glitch_idle: got %h want %h", obs, exp_v); end
    send_frame(8'h42, 1'b1, 0);
    exp_v = st(8'h42, 0, 0, 3'd1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL glitch_next: got %h want %h", obs, exp_v); end
    pop();
  endtask

  task automatic test_frame_err();
    send_frame(8'h66, 1'b0, 500);
    exp_v = st(8'h00, 1, 0, 3'd0, 1, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ferr_set: got %h want %h", obs, exp_v); end
    send_frame(8'h2C, 1'b1, 0);
    exp_v = st(8'h2C, 0, 0, 3'd1, 1, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ferr_next: got %h want %h", obs, exp_v); end
    pulse_clr();
    exp_v = st(8'h2C, 0, 0, 3'd1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ferr_clr: got %h want %h", obs, exp_v); end
    pop();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] fill [4];
    logic [7:0] drain [4];
    fill  = '{8'h11, 8'h22, 8'h44, 8'h88};
    drain = '{8'h22, 8'h44, 8'h88, 8'h33};
    for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1, 0);
    exp_v = st(8'h11, 0, 1, 3'd4, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fpp_full: got %h want %h", obs, exp_v); end
    fork
      send_frame(8'h33, 1'b1, 0);
      begin
        tick(990);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
      end
    join
    exp_v = st(8'h22, 0, 1, 3'd4, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fpp_same_cycle: got %h want %h", obs, exp_v); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data !== drain[i]) begin
        bad++; $display("FAIL fpp_drain%0d: got %h want %h", i, rd_data, drain[i]);
      end
      pop();
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty: empty=%b want 1", empty); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h42, 1'b1, 0);
    fork
      send_frame(8'h14, 1'b1, 0);
      begin
        tick(5 * CPB + 50);
        rst_n = 1'b0;
        tick(2);
        exp_v = st(8'h00, 1, 0, 3'd0, 0, 0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid: got %h want %h", obs, exp_v); end
      end
    join
    rst_n = 1'b1;
    tick(5);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rst_release: got %h want %h", obs, exp_v); end
    send_frame(8'h14, 1'b1, 0);
    exp_v = st(8'h14, 0, 0, 3'd1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rst_after: got %h want %h", obs, exp_v); end
    pop();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
